timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports, one per line as follows:
- clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- addr  in  2  word offset: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped
- we  in  1  write strobe from the bridge, sampled on clk rising edge
- wdata  in  32  write data
- rdata  out  32  read data, combinational from addr
- irq  out  1  interrupt request to the bridge HWInt line
REQ-003 CTRL fields SHALL be:
- bit0 EN, default 0, counting enable
- bits2:1 MODE, default 00, 00 = one-shot, 01 = auto-reload, 1x = one-shot
- bit3 IM, default 0, interrupt mask (1 = irq enabled)
- bits31:4 reserved, read 0

Function
REQ-004 rdata SHALL return {28'b0, CTRL[3:0]}, PRESET, COUNT or 0 for addr 0..3 respectively, with no added latency.
REQ-005 Writes SHALL update CTRL[3:0] (addr 0) or PRESET (addr 1). Writes to addr 2 and 3 SHALL be ignored.
REQ-006 The FSM SHALL have the states IDLE, LOAD, CNT and INT.
REQ-007 IDLE: EN=1 -> LOAD; otherwise stay.
REQ-008 LOAD: COUNT <= PRESET -> CNT.
REQ-009 CNT transitions:
- EN=0 -> IDLE, COUNT held.
- EN=1 and COUNT>1 -> COUNT <= COUNT-1, stay in CNT.
- EN=1 and COUNT<=1 -> COUNT <= 0, irq_flag <= 1, go to INT.
REQ-010 INT, one-shot mode: CTRL.EN <= 0 -> IDLE. irq_flag SHALL be held until the next CTRL write.
REQ-011 INT, auto-reload mode: irq_flag <= 0 (one-cycle pulse). If EN=1 -> LOAD, giving a period of PRESET+2 cycles for PRESET>=1. If EN=0 -> IDLE.
REQ-012 irq SHALL equal irq_flag AND CTRL.IM, registered-path only with no combinational path from wdata.
REQ-013 Any CTRL write SHALL clear irq_flag in the same edge.
REQ-014 When a bus write and an FSM update target CTRL in the same cycle, the bus write SHALL win.
REQ-015 A PRESET write during CNT SHALL NOT affect COUNT until the next LOAD.
REQ-016 PRESET=0 or PRESET=1 SHALL yield CNT for one cycle and then INT (no underflow, COUNT never wraps).
REQ-017 Latency: with PRESET=N>=1, irq (IM=1) SHALL rise N+1 rising edges after the edge that writes EN=1 from IDLE.

Reset
REQ-018 reset_n low SHALL asynchronously force state=IDLE, CTRL=0, PRESET=0, COUNT=0, irq_flag=0, and thus irq=0. rdata SHALL reflect the cleared registers.
REQ-019 Reset asserted mid-count SHALL abort the count with no pending irq after release.

Structure
REQ-020 A shared package timer_pkg SHALL hold:
- the state enum
- register offsets (CTRL=0, PRESET=1, COUNT=2)
- CTRL bit positions and MODE encodings
REQ-021 The block SHALL be a single module with no sub-module. Register file and FSM are small enough to stay flat.

Verification
REQ-022 The bench SHALL cover:
- Reset, then read all three offsets -> rdata = 0. Read addr 3 -> 0.
- PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1 in consecutive cycles. irq rises 6 edges after the CTRL write, CTRL then reads 0x8, and irq stays high until a CTRL write of 0x8 drops it next edge.
- PRESET=3, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulses every 5 cycles, EN remains 1.
- PRESET=100, EN=1, write CTRL=0 at COUNT=40 -> state IDLE, COUNT holds 39 or 40 per edge timing, no irq.
- PRESET=0, CTRL=0x9 -> irq asserted 2 edges after the write, COUNT reads 0.
- reset_n pulsed low asynchronously during CNT -> irq=0 and all registers 0 immediately, with no irq after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: FSM states, register offsets and CTRL layout.
// Pure declarations, no logic.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    // MODE values 2'b1x fall back to one-shot behaviour.
    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01
    } mode_e;

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers, one-shot or auto-reload, and a masked irq.
// Reads are combinational; irq rises PRESET+1 edges after the enabling CTRL write.
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic ctrl_wr;
    logic preset_wr;
    logic en;
    logic reload;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);
    // EN as it will be after this edge, so the enabling write itself moves IDLE to LOAD.
    assign en        = ctrl_wr ? wdata[CTRL_EN] : ctrl_q[CTRL_EN];
    assign reload    = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (reload) begin
                    irq_flag_d = 1'b0;
                    state_d    = en ? ST_LOAD : ST_IDLE;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes take priority over any FSM update of CTRL and the irq flag.
        if (ctrl_wr) begin
            ctrl_d     = wdata[3:0];
            irq_flag_d = 1'b0;
        end
        if (preset_wr) preset_d = wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata = {28'b0, ctrl_q};
            ADDR_PRESET: rdata = preset_q;
            ADDR_COUNT:  rdata = count_q;
            default:     rdata = '0;
        endcase
    end

    assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register table, directed timing sequences, randomized runs.
module tb_timer_counter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks;
    int n_fail;

    timer_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check("reset_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] held;
        int unsigned p, m, len, n, r, ecount, eirq, ectrl, erd;
        logic [1:0]  mode, a;
        logic        im, rl;
        logic [3:0]  wctrl;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        addr     = '0;
        we       = 1'b0;
        wdata    = '0;

        vt[0] = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0};
        vt[1] = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0};
        vt[2] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0};
        vt[3] = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0};
        vt[4] = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF};
        vt[5] = '{1'b1, 2'd2, 32'h00001234, 2'd2, 32'h0};
        vt[6] = '{1'b1, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h0};
        vt[7] = '{1'b1, 2'd0, 32'hFFFFFFF6, 2'd0, 32'h6};
        vt[8] = '{1'b1, 2'd0, 32'h0,        2'd0, 32'h0};
        vt[9] = '{1'b0, 2'd0, 32'h0,        2'd1, 32'hDEADBEEF};

        repeat (3) @(posedge clk);
        #2;
        check("reset_irq_init", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;

        // Register access table
        for (int i = 0; i < 10; i++) begin
            addr  = vt[i].waddr;
            wdata = vt[i].wdata;
            we    = vt[i].we;
            tick();
            we = 1'b0;
            rd(vt[i].raddr, v);
            check($sformatf("table_%0d", i), v, vt[i].exp);
            check($sformatf("table_irq_%0d", i), {31'b0, irq}, 32'd0);
        end
        pulse_reset();

        // One-shot, PRESET=5
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 5; e++) begin
            tick();
            rd(2'd2, v);
            check($sformatf("os5_count_e%0d", e), v, 32'(6 - e));
            check($sformatf("os5_irq_low_e%0d", e), {31'b0, irq}, 32'd0);
        end
        tick();
        check("os5_irq_rise", {31'b0, irq}, 32'd1);
        rd(2'd2, v);
        check("os5_count_zero", v, 32'd0);
        tick();
        rd(2'd0, v);
        check("os5_ctrl_en_cleared", v, 32'h8);
        repeat (3) tick();
        check("os5_irq_held", {31'b0, irq}, 32'd1);
        wr(2'd0, 32'h8);
        check("os5_irq_cleared", {31'b0, irq}, 32'd0);
        pulse_reset();

        // Auto-reload, PRESET=3: period 5
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 16; e++) begin
            tick();
            check($sformatf("ar3_irq_e%0d", e), {31'b0, irq}, (e % 5 == 4) ? 32'd1 : 32'd0);
            rd(2'd0, v);
            check($sformatf("ar3_ctrl_e%0d", e), v, 32'hB);
        end
        pulse_reset();

        // PRESET=100, PRESET rewrite mid-count, abort at COUNT=40
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        for (int e = 1; e <= 61; e++) begin
            if (e == 5) wr(2'd1, 32'd7);
            else tick();
            rd(2'd2, v);
            check($sformatf("p100_count_e%0d", e), v, 32'(101 - e));
        end
        wr(2'd0, 32'h0);
        rd(2'd2, held);
        check("abort_count_39_or_40", {31'b0, (held == 32'd39 || held == 32'd40)}, 32'd1);
        repeat (5) tick();
        rd(2'd2, v);
        check("abort_count_held", v, held);
        check("abort_no_irq", {31'b0, irq}, 32'd0);
        rd(2'd0, v);
        check("abort_ctrl", v, 32'h0);
        rd(2'd1, v);
        check("abort_preset", v, 32'd7);
        pulse_reset();

        // PRESET=0
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        check("p0_irq_e1", {31'b0, irq}, 32'd0);
        tick();
        check("p0_irq_e2", {31'b0, irq}, 32'd1);
        rd(2'd2, v);
        check("p0_count", v, 32'd0);
        pulse_reset();

        // Asynchronous reset during CNT
        wr(2'd1, 32'd50);
        wr(2'd0, 32'hB);
        repeat (10) tick();
        reset_n = 1'b0;
        #1;
        check("arst_irq", {31'b0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            check($sformatf("arst_reg_%0d", i), v, 32'd0);
        end
        reset_n = 1'b1;
        held = 32'd0;
        for (int e = 0; e < 60; e++) begin
            tick();
            if (irq) held = 32'd1;
        end
        check("arst_no_irq_after", held, 32'd0);
        rd(2'd2, v);
        check("arst_count_after", v, 32'd0);
        pulse_reset();

        // Randomized runs against an arithmetic timeline model
        for (int s = 0; s < 25; s++) begin
            p     = $urandom_range(0, 12);
            mode  = 2'($urandom_range(0, 3));
            im    = 1'($urandom_range(0, 1));
            wctrl = {im, mode, 1'b1};
            rl    = (mode == 2'b01);
            m     = (p == 0) ? 1 : p;
            len   = m + 2;
            n     = $urandom_range(1, 3 * len);
            wr(2'd1, 32'(p));
            wr(2'd0, {28'b0, wctrl});
            for (int e = 1; e <= int'(n); e++) begin
                tick();
                if (rl) begin
                    r      = (e - 1) % len;
                    ecount = (r < m) ? p - r : 0;
                    eirq   = (r == m && im) ? 1 : 0;
                    ectrl  = wctrl;
                end else begin
                    ecount = (e <= int'(m)) ? p - (e - 1) : 0;
                    eirq   = (e >= int'(m) + 1 && im) ? 1 : 0;
                    ectrl  = (e >= int'(m) + 2) ? (wctrl & 4'hE) : wctrl;
                end
                a = 2'($urandom_range(0, 3));
                case (a)
                    2'd0:    erd = ectrl;
                    2'd1:    erd = p;
                    2'd2:    erd = ecount;
                    default: erd = 0;
                endcase
                rd(a, v);
                check($sformatf("rnd%0d_e%0d_rd%0d", s, e, a), v, erd);
                check($sformatf("rnd%0d_e%0d_irq", s, e), {31'b0, irq}, eirq);
            end
            pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
